// File: rtl/iic_cmd_fifo_pio.sv
`default_nettype none
// ============================================================================
// Module   : iic_cmd_fifo_pio
// Brief    : Avalon-MM command FIFO feeding the I2C master over valid/ready,
//            with status/control/flush, sticky overflow and legacy out_port.
//            Optional IRQMASK register and irq output with IIC_CMD_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iic_cmd_fifo_pio #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] c_ADDR_DATA   = 2'd0;
  localparam logic [1:0] c_ADDR_STATUS = 2'd1;
  localparam logic [1:0] c_ADDR_CTRL   = 2'd2;
  localparam logic [1:0] c_ADDR_IRQ    = 2'd3;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]  r_wr_cnt;
  logic [LVL_W-1:0]  r_rd_cnt;
  logic [DATA_W-1:0] r_out_port;
  logic              r_overflow;
  logic              r_enable;

  logic              w_write;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_full;
  logic              w_empty;
  logic [LVL_W-1:0]  w_level;
  logic [31:0]       w_rd;
  logic              w_unused_wdata;

  assign w_write    = chipselect && !write_n;
  assign w_push_req = w_write && (address == c_ADDR_DATA);
  assign w_flush    = w_write && (address == c_ADDR_CTRL) && writedata[1];

  // Counters run one bit wider than the pointers so full and empty differ.
  assign w_level = r_wr_cnt - r_rd_cnt;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == LVL_W'(DEPTH));

  assign cmd_valid = !w_empty && r_enable;
  assign w_pop     = cmd_valid && cmd_ready;
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign cmd_data  = w_empty ? '0 : r_mem[r_rd_cnt[PTR_W-1:0]];
  assign out_port  = r_out_port;

  assign w_unused_wdata = ^writedata;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_cnt[PTR_W-1:0]] <= writedata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_out_port <= '0;
      r_overflow <= 1'b0;
      r_enable   <= 1'b1;
    end else begin
      if (w_flush) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end else begin
        if (w_push) r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_pop)  r_rd_cnt <= r_rd_cnt + 1'b1;
      end

      if (w_push_req) r_out_port <= writedata[DATA_W-1:0];

      if (w_write && (address == c_ADDR_STATUS) && writedata[18]) begin
        r_overflow <= 1'b0;
      end else if (w_push_req && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end

      // A flush write leaves enable untouched so software can flush in one access.
      if (w_write && (address == c_ADDR_CTRL) && !writedata[1]) begin
        r_enable <= writedata[0];
      end
    end
  end

`ifdef IIC_CMD_IRQ_EN
  logic [1:0] r_irq_mask;
  logic       r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= 2'b00;
      r_irq      <= 1'b0;
    end else begin
      if (w_write && (address == c_ADDR_IRQ)) r_irq_mask <= writedata[1:0];
      r_irq <= (w_empty && r_irq_mask[0]) || (r_overflow && r_irq_mask[1]);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (address)
      c_ADDR_DATA: w_rd[DATA_W-1:0] = r_out_port;
      c_ADDR_STATUS: begin
        w_rd[LVL_W-1:0] = w_level;
        w_rd[16]        = w_empty;
        w_rd[17]        = w_full;
        w_rd[18]        = r_overflow;
        w_rd[19]        = cmd_valid;
      end
      c_ADDR_CTRL: w_rd[0] = r_enable;
`ifdef IIC_CMD_IRQ_EN
      c_ADDR_IRQ: w_rd[1:0] = r_irq_mask;
`endif
      default: w_rd = '0;
    endcase
  end

  assign readdata = w_rd;

endmodule
`default_nettype wire

// File: tb/tb_iic_cmd_fifo_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_cmd_fifo_pio
// Brief    : Scoreboard bench for iic_cmd_fifo_pio (DATA_W=24, DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_cmd_fifo_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [23:0] out_port;
  logic [23:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  iic_cmd_fifo_pio #(.DATA_W(24), .DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must present the oldest expected command word.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", {8'h0, cmd_data}, 32'hFFFF_FFFF);
        end else begin
          check("cmd_data_pop", {8'h0, cmd_data}, exp_q.pop_front());
        end
      end
`ifndef IIC_CMD_IRQ_EN
      check("irq_tied_low", {31'h0, irq}, 32'h0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push(input logic [31:0] d);
    exp_q.push_back(d);
    wr(2'd0, d);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    cmd_ready = 1'b0;
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    cmd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Reset state
    rd(2'd1, 32'h0001_0000, "reset_status");
    check("reset_out_port", {8'h0, out_port}, 32'h0);
    check("reset_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("reset_cmd_data", {8'h0, cmd_data}, 32'h0);
    rd(2'd2, 32'h0000_0001, "reset_enable");

    // Single word, fall-through latency, one handshake
    push(32'h00A0_5A12);
    check("single_valid", {31'h0, cmd_valid}, 32'h1);
    check("single_data", {8'h0, cmd_data}, 32'h00A0_5A12);
    check("single_out_port", {8'h0, out_port}, 32'h00A0_5A12);
    rd(2'd1, 32'h0008_0001, "single_status");
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("single_valid_after_pop", {31'h0, cmd_valid}, 32'h0);
    rd(2'd1, 32'h0001_0000, "single_status_empty");

    // Overflow: nine writes into eight entries
    for (int i = 1; i <= 8; i++) push(i);
    wr(2'd0, 32'h9);
    rd(2'd1, 32'h000E_0008, "ovf_status");
    rd(2'd0, 32'h0000_0009, "ovf_out_port");
    drain("ovf_drain");
    rd(2'd1, 32'h0005_0000, "ovf_sticky_empty");
    wr(2'd1, 32'h0004_0000);
    rd(2'd1, 32'h0001_0000, "ovf_cleared");

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(32'h11 + i);
    exp_q.push_back(32'h0000_BEEF);
    cmd_ready = 1'b1;
    wr(2'd0, 32'h0000_BEEF);
    cmd_ready = 1'b0;
    rd(2'd1, 32'h000A_0008, "full_pushpop_status");
    drain("full_pushpop_drain");
    rd(2'd1, 32'h0001_0000, "full_pushpop_empty");

    // Flush with a concurrent handshake, then enable gating
    push(32'h21);
    push(32'h22);
    push(32'h23);
    cmd_ready = 1'b1;
    wr(2'd2, 32'h2);
    cmd_ready = 1'b0;
    exp_q.delete();
    rd(2'd1, 32'h0001_0000, "flush_status");
    check("flush_valid", {31'h0, cmd_valid}, 32'h0);
    rd(2'd2, 32'h0000_0001, "flush_enable_kept");
    wr(2'd2, 32'h0);
    push(32'h55);
    cmd_ready = 1'b1;
    tick(2);
    cmd_ready = 1'b0;
    check("disabled_valid", {31'h0, cmd_valid}, 32'h0);
    rd(2'd1, 32'h0000_0001, "disabled_status");
    rd(2'd2, 32'h0000_0000, "disabled_ctrl");
    wr(2'd2, 32'h1);
    check("reenabled_valid", {31'h0, cmd_valid}, 32'h1);
    check("reenabled_data", {8'h0, cmd_data}, 32'h55);
    drain("reenabled_drain");

    // Interrupt register
`ifdef IIC_CMD_IRQ_EN
    wr(2'd3, 32'h1);
    tick(1);
    check("irq_empty_set", {31'h0, irq}, 32'h1);
    rd(2'd3, 32'h0000_0001, "irqmask_read");
    cmd_ready = 1'b0;
    push(32'h7);
    tick(1);
    check("irq_empty_clear", {31'h0, irq}, 32'h0);
    drain("irq_drain");
    tick(1);
    check("irq_empty_again", {31'h0, irq}, 32'h1);
    wr(2'd3, 32'h0);
    tick(1);
    check("irq_mask_clear", {31'h0, irq}, 32'h0);
`else
    wr(2'd3, 32'h3);
    rd(2'd3, 32'h0000_0000, "addr3_reads_zero");
    tick(1);
    check("irq_low", {31'h0, irq}, 32'h0);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
